// File: rtl/neopixel_frame_sequencer.sv
// Double-buffered NeoPixel frame sequencer: streams the active buffer into a strand
// controller channel by channel and can redisplay it rotated by one pixel each frame period.
module neopixel_frame_sequencer #(
    parameter int NUM_PIXELS   = 5,
    parameter int FRAME_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_pixel,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_level,
    input  logic       commit,
    input  logic       auto_rotate,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic       load_color,
    output logic [1:0] color_index,
    output logic [2:0] pixel_index,
    output logic [7:0] color_level,
    output logic       send_it,
    output logic       busy,
    output logic       frame_done,
    output logic       wr_error
);
    localparam int            FW         = $clog2(FRAME_CYCLES);
    localparam logic [2:0]    LAST_PIXEL = 3'(NUM_PIXELS - 1);
    localparam logic [FW-1:0] LAST_COUNT = FW'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, ACK, DRAIN, HOLD} state_t;

    state_t        state;
    logic [7:0]    shadow      [NUM_PIXELS][3];
    logic [7:0]    shadow_next [NUM_PIXELS][3];
    logic [7:0]    active      [NUM_PIXELS][3];
    logic [2:0]    walk_pixel;
    logic [1:0]    walk_channel;
    logic [FW-1:0] frame_count;
    logic          pending;
    logic          wr_illegal;
    logic          wr_legal;
    logic          copy_request;

    assign wr_illegal   = wr_en && (int'(wr_pixel) >= NUM_PIXELS || wr_color == 2'b11);
    assign wr_legal     = wr_en && !wr_illegal;
    assign copy_request = commit || pending;

    // A copy taken in the same cycle as a host write must already contain that write.
    // NOTE: blocking assignments in always_comb, with the full default first, so the
    // indexed update overrides it and no latch can be inferred.
    always_comb begin
        shadow_next = shadow;
        if (wr_legal) shadow_next[wr_pixel][wr_color] = wr_level;
    end

    // NOTE: both buffers are flop arrays with a defined all-zero reset value, so they are
    // cleared in the async reset branch; a RAM macro could not honour this.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIXELS; p++)
                for (int c = 0; c < 3; c++)
                    shadow[p][c] <= '0;
        end else begin
            shadow <= shadow_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            load_color   <= 1'b0;
            color_index  <= '0;
            pixel_index  <= '0;
            color_level  <= '0;
            send_it      <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            wr_error     <= 1'b0;
            pending      <= 1'b0;
            walk_pixel   <= '0;
            walk_channel <= '0;
            frame_count  <= '0;
            for (int p = 0; p < NUM_PIXELS; p++)
                for (int c = 0; c < 3; c++)
                    active[p][c] <= '0;
        end else begin
            load_color <= 1'b0;
            send_it    <= 1'b0;
            frame_done <= 1'b0;
            wr_error   <= wr_illegal;

            if (commit && state != IDLE && state != HOLD) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (copy_request) begin
                        active       <= shadow_next;
                        pending      <= 1'b0;
                        walk_pixel   <= '0;
                        walk_channel <= '0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    // A strobe cycle never issues another strobe; ready is re-sampled next cycle.
                    if (ready_to_load && !load_color) begin
                        load_color  <= 1'b1;
                        pixel_index <= walk_pixel;
                        color_index <= walk_channel;
                        color_level <= active[walk_pixel][walk_channel];
                        if (walk_channel == 2'd2) begin
                            walk_channel <= '0;
                            walk_pixel   <= walk_pixel + 3'd1;
                        end else begin
                            walk_channel <= walk_channel + 2'd1;
                        end
                        if (walk_pixel == LAST_PIXEL && walk_channel == 2'd2) state <= SEND;
                    end
                end
                SEND: begin
                    if (ready_to_send) begin
                        send_it <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (!ready_to_send) state <= DRAIN;
                end
                DRAIN: begin
                    if (ready_to_send) begin
                        frame_done  <= 1'b1;
                        frame_count <= '0;
                        if (auto_rotate) begin
                            state <= HOLD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (copy_request) begin
                        active       <= shadow_next;
                        pending      <= 1'b0;
                        frame_count  <= '0;
                        walk_pixel   <= '0;
                        walk_channel <= '0;
                        state        <= LOAD;
                    end else if (!auto_rotate) begin
                        frame_count <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (frame_count == LAST_COUNT) begin
                        for (int p = 0; p < NUM_PIXELS; p++)
                            for (int c = 0; c < 3; c++)
                                active[p][c] <= active[(p + 1) % NUM_PIXELS][c];
                        frame_count  <= '0;
                        walk_pixel   <= '0;
                        walk_channel <= '0;
                        state        <= LOAD;
                    end else begin
                        frame_count <= frame_count + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Scoreboard bench for neopixel_frame_sequencer: stimulus pushes hand-computed strobe
// events into a queue, a negedge monitor pops and compares every strobe the DUT issues.
module tb_neopixel_frame_sequencer;
    localparam int NP = 5;
    localparam int FC = 10;

    typedef enum logic [1:0] {EV_LOAD, EV_SEND, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [2:0] pixel;
        logic [1:0] color;
        logic [7:0] level;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_pixel = '0;
    logic [1:0] wr_color = '0;
    logic [7:0] wr_level = '0;
    logic       commit = 1'b0;
    logic       auto_rotate = 1'b0;
    logic       ready_to_load = 1'b1;
    logic       ready_to_send = 1'b1;
    logic       load_color, send_it, busy, frame_done, wr_error;
    logic [1:0] color_index;
    logic [2:0] pixel_index;
    logic [7:0] color_level;

    ev_t        sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         load_count = 0;
    int         err_count = 0;
    int         strobe_count = 0;
    logic       rl_q = 1'b0;
    logic       toggle_rl = 1'b0;
    logic [7:0] img [NP][3];

    neopixel_frame_sequencer #(.NUM_PIXELS(NP), .FRAME_CYCLES(FC)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel),
        .wr_color(wr_color), .wr_level(wr_level), .commit(commit),
        .auto_rotate(auto_rotate), .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send), .load_color(load_color),
        .color_index(color_index), .pixel_index(pixel_index),
        .color_level(color_level), .send_it(send_it), .busy(busy),
        .frame_done(frame_done), .wr_error(wr_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic ev_t mk(input ev_kind_t k, input int p, input int c, input logic [7:0] l);
        ev_t e;
        e.kind  = k;
        e.pixel = 3'(p);
        e.color = 2'(c);
        e.level = l;
        return e;
    endfunction

    task automatic observe(input ev_t got);
        ev_t exp;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d pixel=%0d color=%0d level=0x%0h, expected none",
                     got.kind, got.pixel, got.color, got.level);
        end else begin
            exp = sb.pop_front();
            check($sformatf("event(kind=%0d,p=%0d,c=%0d)", exp.kind, exp.pixel, exp.color),
                  32'(got), 32'(exp));
        end
    endtask

    // Ready as sampled by the DUT at the edge preceding each negedge.
    always @(posedge clock) rl_q <= ready_to_load;

    always @(negedge clock) begin
        if (!reset) begin
            if (load_color || send_it) begin
                strobe_count++;
                check("load_send_exclusive", 32'(load_color & send_it), 32'd0);
            end
            if (wr_error) begin
                err_count++;
                observe(mk(EV_ERR, 0, 0, 8'h00));
            end
            if (load_color) begin
                load_count++;
                check("load_after_ready_high", 32'(rl_q), 32'd1);
                observe(mk(EV_LOAD, int'(pixel_index), int'(color_index), color_level));
            end
            if (send_it)    observe(mk(EV_SEND, 0, 0, 8'h00));
            if (frame_done) observe(mk(EV_DONE, 0, 0, 8'h00));
        end
    end

    // Strand controller: keeps ready_to_send high for 4 cycles after send_it, low for 3.
    initial begin
        forever begin
            @(negedge clock);
            if (send_it) begin
                repeat (4) @(negedge clock);
                ready_to_send = 1'b0;
                repeat (3) @(negedge clock);
                ready_to_send = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (toggle_rl) ready_to_load = !ready_to_load;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_img();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                img[p][c] = 8'h00;
    endtask

    task automatic push_img();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                sb.push_back(mk(EV_LOAD, p, c, img[p][c]));
        sb.push_back(mk(EV_SEND, 0, 0, 8'h00));
        sb.push_back(mk(EV_DONE, 0, 0, 8'h00));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_write(input int p, input int c, input logic [7:0] l, input bit expect_err);
        wr_en = 1'b1;
        wr_pixel = 3'(p);
        wr_color = 2'(c);
        wr_level = l;
        if (expect_err) sb.push_back(mk(EV_ERR, 0, 0, 8'h00));
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clock);
        commit = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, "_idle_reached"}, 32'(n < budget), 32'd1);
        check({name, "_queue_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_load_color"},  32'(load_color),  32'd0);
        check({tag, "_color_index"}, 32'(color_index), 32'd0);
        check({tag, "_pixel_index"}, 32'(pixel_index), 32'd0);
        check({tag, "_color_level"}, 32'(color_level), 32'd0);
        check({tag, "_send_it"},     32'(send_it),     32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check({tag, "_wr_error"},    32'(wr_error),    32'd0);
    endtask

    initial begin
        int n;
        int k;
        int base;

        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Single green write at pixel 2, readies held high.
        do_write(2, 2, 8'h7F, 1'b0);
        clear_img();
        img[2][2] = 8'h7F;
        push_img();
        base = load_count;
        pulse_commit();
        check("t1_busy_in_frame", 32'(busy), 32'd1);
        wait_idle("t1", 300);
        check("t1_load_count", 32'(load_count - base), 32'd15);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Same frame with ready_to_load toggling every cycle.
        push_img();
        base = load_count;
        toggle_rl = 1'b1;
        pulse_commit();
        wait_idle("t2", 400);
        toggle_rl = 1'b0;
        ready_to_load = 1'b1;
        check("t2_load_count", 32'(load_count - base), 32'd15);

        // Two commits during ACK with a write between: one follow-up frame carrying it.
        push_img();
        pulse_commit();
        n = 0;
        while (!send_it && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t3_send_seen", 32'(n < 200), 32'd1);
        pulse_commit();
        do_write(0, 0, 8'h11, 1'b0);
        pulse_commit();
        img[0][0] = 8'h11;
        push_img();
        wait_idle("t3", 400);
        repeat (30) @(negedge clock);
        check("t3_no_extra_frame_queue", 32'(sb.size()), 32'd0);
        check("t3_no_extra_frame_busy", 32'(busy), 32'd0);

        // Auto-rotate: pixel 0 red moves to pixel 4 in the second frame.
        do_write(2, 2, 8'h00, 1'b0);
        do_write(0, 0, 8'hFF, 1'b0);
        auto_rotate = 1'b1;
        clear_img();
        img[0][0] = 8'hFF;
        push_img();
        clear_img();
        img[4][0] = 8'hFF;
        push_img();
        pulse_commit();
        n = 0;
        while (!frame_done && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("t4_first_frame_done", 32'(n < 300), 32'd1);
        // LOAD is entered FC cycles after frame_done; the registered strobe adds one more.
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!load_color && n < 50);
        check("t4_rotate_latency", 32'(n), 32'(FC + 1));
        auto_rotate = 1'b0;
        wait_idle("t4", 400);

        // Illegal writes leave the buffers alone.
        do_write(0, 0, 8'h00, 1'b0);
        base = err_count;
        do_write(1, 3, 8'hAA, 1'b1);
        do_write(5, 0, 8'hBB, 1'b1);
        @(negedge clock);
        check("t5_wr_error_pulses", 32'(err_count - base), 32'd2);
        clear_img();
        push_img();
        pulse_commit();
        wait_idle("t5", 300);

        // Reset during the 7th load abandons the frame.
        do_write(1, 1, 8'h22, 1'b0);
        clear_img();
        img[1][1] = 8'h22;
        for (int i = 0; i < 7; i++) sb.push_back(mk(EV_LOAD, i / 3, i % 3, img[i / 3][i % 3]));
        pulse_commit();
        n = 0;
        k = 0;
        while (k < 7 && n < 200) begin
            @(negedge clock);
            n++;
            if (load_color) k++;
        end
        check("t6_seventh_load_seen", 32'(k), 32'd7);
        #1 reset = 1'b1;
        #1 check_outputs_zero("t6_reset");
        base = strobe_count;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("t6_no_strobes_after_reset", 32'(strobe_count - base), 32'd0);
        check("t6_idle_after_reset", 32'(busy), 32'd0);
        check("t6_queue_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/neopixel_frame_sequencer.md
NEOPIXEL_FRAME_SEQUENCER -- requirements
Module: neopixel_frame_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, default 5: number of pixels on the strand; legal range 1..8.
REQ-002 Parameter FRAME_CYCLES, default 1000000: clock cycles per auto-rotate frame period (20 ms at 50 MHz); minimum 2.
REQ-003 clock  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  host write strobe into the shadow buffer.
REQ-006 wr_pixel  input  3  target pixel of the host write.
REQ-007 wr_color  input  2  target channel of the host write: 00 red, 01 blue, 10 green, 11 illegal.
REQ-008 wr_level  input  8  channel intensity for the host write.
REQ-009 commit  input  1  single-cycle request to display the shadow buffer.
REQ-010 auto_rotate  input  1  level; when high, the frame is redisplayed rotated every FRAME_CYCLES.
REQ-011 ready_to_load  input  1  strand controller accepts a color load this cycle.
REQ-012 ready_to_send  input  1  strand controller accepts send_it this cycle.
REQ-013 load_color  output  1  one-cycle color load strobe to the strand controller.
REQ-014 color_index  output  2  channel of the current load, same encoding as wr_color.
REQ-015 pixel_index  output  3  pixel of the current load.
REQ-016 color_level  output  8  intensity of the current load.
REQ-017 send_it  output  1  one-cycle send strobe to the strand controller.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 frame_done  output  1  one-cycle pulse when the strand controller finishes a frame.
REQ-020 wr_error  output  1  one-cycle pulse, registered, the cycle after an illegal write.

Function
REQ-021 Storage: shadow buffer and active buffer, each NUM_PIXELS x 3 channels x 8 bits.
- Host writes update the shadow buffer only.
- The sequencer reads the active buffer only.
REQ-022 Illegal write: wr_pixel >= NUM_PIXELS or wr_color == 11.
- No buffer changes.
- wr_error pulses on the next cycle.
REQ-023 The FSM has exactly these states: IDLE, LOAD, SEND, ACK, DRAIN, HOLD.
REQ-024 IDLE:
- On commit, or on a pending commit flag, copy shadow to active in that cycle, clear the pending flag, go to LOAD.
REQ-025 LOAD: walk (pixel 0..NUM_PIXELS-1) outer, (channel 00, 01, 10) inner.
- load_color asserts for exactly one cycle per value, only in a cycle where ready_to_load is high.
- pixel_index, color_index and color_level are valid whenever load_color is high.
- If ready_to_load is low, the walk stalls with load_color low.
- After the 3*NUM_PIXELS-th load, go to SEND.
REQ-026 SEND: assert send_it for exactly one cycle in the first cycle where ready_to_send is high, then go to ACK.
REQ-027 ACK: wait for ready_to_send low (transmission started), then go to DRAIN.
REQ-028 DRAIN: wait for ready_to_send high again.
- In that cycle, pulse frame_done and go to HOLD if auto_rotate is high, else go to IDLE.
REQ-029 HOLD: a frame counter counts from 0.
- When the count reaches FRAME_CYCLES-1, rotate the active buffer by one pixel (new pixel i = old pixel (i+1) mod NUM_PIXELS, all three channels), clear the counter, go to LOAD.
- If auto_rotate is low in any HOLD cycle, go to IDLE and clear the counter.
- A commit or pending commit in HOLD preempts the rotation: copy shadow to active, clear the counter, go to LOAD.
REQ-030 A commit received in any state other than IDLE or HOLD sets the pending flag.
- Multiple such commits collapse into one.
- Shadow writes made after the commit but before the copy are included in the copy.
REQ-031 Simultaneous write and copy in one cycle: the copied value includes that cycle's write.
REQ-032 load_color and send_it are never high in the same cycle.
REQ-033 Outputs are registered, with no combinational path from ready_to_load or ready_to_send to any output.
- One cycle of latency from a qualifying ready to the strobe.
- After each strobe, ready is re-sampled on the following cycle before another strobe is issued.

Reset
REQ-034 On reset assertion, the following take effect immediately:
- state IDLE
- all outputs 0
- both buffers all-zero
- pending flag, walk counters and frame counter cleared
REQ-035 Reset asserted mid-frame abandons the frame, with no further load_color or send_it strobes; frame_done does not pulse.

Verification
REQ-036 The bench shall cover: write pixel 2 green = 0x7F, commit, ready_to_load and ready_to_send held high -> 15 loads in order (0,00)...(4,10) with (2,10)=0x7F and all others 0, then exactly one send_it.
REQ-037 The bench shall cover: ready_to_load toggled 1-0-1 every cycle during LOAD -> load count stays 15, order unchanged, no load_color while ready_to_load was low on the preceding cycle.
REQ-038 The bench shall cover: commit pulsed twice during ACK, with a write of pixel 0 red = 0x11 in between -> exactly one follow-up frame, and it carries 0x11.
REQ-039 The bench shall cover: FRAME_CYCLES=10, auto_rotate=1, pixel 0 red=0xFF, others 0 -> the second frame has pixel 4 red=0xFF, and the rotation load starts 10 cycles after frame_done.
REQ-040 The bench shall cover: a write with wr_color=11, then a write with wr_pixel=5 -> two wr_error pulses, and the next frame's loads are all 0.
REQ-041 The bench shall cover: reset asserted during the 7th load -> outputs 0 immediately; after release with no commit, no strobes occur.
